// File: rtl/screen_state_ctrl.sv
// rtl/screen_state_ctrl.sv - screen sequencer: keycode decode, one-hot screen flags, Ready gate, GameRst pulse
// Optional feature macro: SCREEN_EXIT_TIMEOUT_EN (exit screen auto-returns to main after EXIT_FRAMES ticks)
`timescale 1ns/1ps

module screen_state_ctrl #(
    parameter int READY_FRAMES = 120,
    parameter int EXIT_FRAMES  = 180
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic       MainS,
    output logic       StartScreen,
    output logic       Instructions,
    output logic       Game1Screen,
    output logic       Game2Screen,
    output logic       PauseScreen1,
    output logic       PauseScreen2,
    output logic       ExitScreen,
    output logic       Ready,
    output logic       GameRst
);

    // A zero READY_FRAMES would give a zero-width counter, so keep at least one bit
    localparam int RW = (READY_FRAMES > 0) ? $clog2(READY_FRAMES + 1) : 1;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_I     = 8'h0C;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_1     = 8'h1E;
    localparam logic [7:0] KEY_2     = 8'h1F;
    localparam logic [7:0] KEY_P     = 8'h13;

    typedef enum logic [2:0] {
        S_MAIN,
        S_INSTR,
        S_START,
        S_GAME1,
        S_GAME2,
        S_PAUSE1,
        S_PAUSE2,
        S_EXIT
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [7:0]    key_q;
    logic [7:0]    key_prev;
    logic          press;
    logic          sync1;
    logic          sync2;
    logic          sync3;
    logic          tick;
    logic          in_game;
    logic          transition;
    logic          game_entry;
    logic [RW-1:0] rdy_cnt;
    logic          game_rst_q;

`ifdef SCREEN_EXIT_TIMEOUT_EN
    localparam int EW = (EXIT_FRAMES > 0) ? $clog2(EXIT_FRAMES + 1) : 1;
    logic [EW-1:0] exit_cnt;
`else
    logic          unused_exit_cfg;
    assign unused_exit_cfg = (EXIT_FRAMES > 0);
`endif

    // Register the keycode twice; an event is a new nonzero code in key_q
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            key_q    <= 8'h00;
            key_prev <= 8'h00;
        end else begin
            key_q    <= keycode;
            key_prev <= key_q;
        end
    end

    assign press = (key_q != key_prev) && (key_q != 8'h00);

    // Two-flop synchroniser for frame_clk plus an edge register for tick detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_MAIN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode from key events (and the exit timeout when built)
    always_comb begin
        next_state = state;
        case (state)
            S_MAIN: begin
                if (press && key_q == KEY_ENTER)  next_state = S_START;
                else if (press && key_q == KEY_I) next_state = S_INSTR;
            end
            S_INSTR: begin
                if (press && key_q == KEY_ESC) next_state = S_MAIN;
            end
            S_START: begin
                if (press && key_q == KEY_1)        next_state = S_GAME1;
                else if (press && key_q == KEY_2)   next_state = S_GAME2;
                else if (press && key_q == KEY_ESC) next_state = S_MAIN;
            end
            S_GAME1: begin
                if (press && key_q == KEY_P) next_state = S_PAUSE1;
            end
            S_GAME2: begin
                if (press && key_q == KEY_P) next_state = S_PAUSE2;
            end
            S_PAUSE1: begin
                if (press && key_q == KEY_P)        next_state = S_GAME1;
                else if (press && key_q == KEY_ESC) next_state = S_EXIT;
            end
            S_PAUSE2: begin
                if (press && key_q == KEY_P)        next_state = S_GAME2;
                else if (press && key_q == KEY_ESC) next_state = S_EXIT;
            end
            S_EXIT: begin
                if (press && key_q == KEY_ENTER) next_state = S_MAIN;
`ifdef SCREEN_EXIT_TIMEOUT_EN
                else if (exit_cnt == '0)         next_state = S_MAIN;
`endif
            end
            default: next_state = S_MAIN;
        endcase
    end

    assign in_game    = (state == S_GAME1) || (state == S_GAME2);
    assign transition = (next_state != state);
    assign game_entry = (state == S_START) &&
                        ((next_state == S_GAME1) || (next_state == S_GAME2));

    // Ready countdown: load on game entry, count ticks while playing, frozen otherwise
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdy_cnt <= '0;
        end else if (game_entry) begin
            rdy_cnt <= RW'(READY_FRAMES);
        end else if (in_game && tick && !transition && rdy_cnt != '0) begin
            rdy_cnt <= rdy_cnt - RW'(1);
        end
    end

    // One-cycle re-home pulse aligned with the first cycle of the new game state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            game_rst_q <= 1'b0;
        end else begin
            game_rst_q <= game_entry;
        end
    end

`ifdef SCREEN_EXIT_TIMEOUT_EN
    // Exit hold counter: load on entry to EXIT, count ticks down while there
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            exit_cnt <= '0;
        end else if (state != S_EXIT && next_state == S_EXIT) begin
            exit_cnt <= EW'(EXIT_FRAMES);
        end else if (state == S_EXIT && tick && exit_cnt != '0) begin
            exit_cnt <= exit_cnt - EW'(1);
        end
    end
`endif

    assign MainS        = (state == S_MAIN);
    assign Instructions = (state == S_INSTR);
    assign StartScreen  = (state == S_START);
    assign Game1Screen  = (state == S_GAME1);
    assign Game2Screen  = (state == S_GAME2);
    assign PauseScreen1 = (state == S_PAUSE1);
    assign PauseScreen2 = (state == S_PAUSE2);
    assign ExitScreen   = (state == S_EXIT);
    assign Ready        = in_game && (rdy_cnt == '0);
    assign GameRst      = game_rst_q;

endmodule
